// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Requester indices; also the encoding of the winner / last_grant bit.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational winner select.
// Round-robin on ties by default; with RAM_ARB_FIXED_PRIO_EN defined,
// requester 0 always wins ties and last_grant is ignored.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any_req,
  output logic       winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick the winning requester index from the current request pair.
  always_comb begin
    any_req = |req;
    winner  = REQ0;
    case (req)
      2'b01:   winner = REQ0;
      2'b10:   winner = REQ1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      2'b11:   winner = REQ0;
`else
      2'b11:   winner = ~last_grant;
`endif
      default: winner = REQ0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer between two masters and a single-port RAM.
// Each transaction takes IDLE -> ACCESS -> RESP; all outputs are registered.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic any_req;
  logic winner;

  rr_arbiter2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Next-state and next-output logic for the three-phase transaction FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata_d      = rdata_q;
    ram_cs_d     = ram_cs_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      IDLE: begin
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        if (any_req) begin
          // Latch the winner's command; it stays frozen through ACCESS.
          state_d     = ACCESS;
          owner_d     = winner;
          ram_cs_d    = 1'b1;
          ram_we_d    = (winner == REQ1) ? we1    : we0;
          ram_addr_d  = (winner == REQ1) ? addr1  : addr0;
          ram_wdata_d = (winner == REQ1) ? wdata1 : wdata0;
          gnt0_d      = (winner == REQ0);
          gnt1_d      = (winner == REQ1);
        end else begin
          ram_cs_d    = 1'b0;
          ram_we_d    = 1'b0;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          gnt0_d      = 1'b0;
          gnt1_d      = 1'b0;
        end
      end
      ACCESS: begin
        // The RAM write commits on this edge; reads are captured here too.
        state_d      = RESP;
        last_grant_d = owner_q;
        ram_cs_d     = 1'b0;
        ram_we_d     = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        ack0_d       = (owner_q == REQ0);
        ack1_d       = (owner_q == REQ1);
        if (!ram_we_q) begin
          rdata_d = ram_rdata;
        end
      end
      RESP: begin
        // Return to IDLE with the RAM bus quiet; requests are not looked at.
        state_d     = IDLE;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
      end
      default: begin
        state_d  = IDLE;
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the RAM strobes immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      owner_q      <= REQ0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      ram_cs_q     <= ram_cs_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural 32x32 RAM model.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, ack0, gnt1, ack1;
  logic [31:0] rdata;
  logic        ram_cs, ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .ack0      (ack0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .ack1      (ack1),
    .rdata     (rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: unwritten word i reads as 0x1000_0000 + i.
  logic [31:0] mem [32];
  logic [31:0] wr_mask = '0;

  always @(posedge clock) begin
    if (ram_cs && ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_mask[ram_addr] <= 1'b1;
    end
  end

  assign ram_rdata = wr_mask[ram_addr] ? mem[ram_addr] : (32'h1000_0000 | {27'd0, ram_addr});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One single-requester transaction; starts from any point that leads into IDLE.
  task automatic do_txn(input logic id, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    @(negedge clock);
    if (id) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else    begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    @(negedge clock);
    chk("access_gnt", {62'd0, gnt1, gnt0}, id ? 64'd2 : 64'd1);
    chk("access_cs_we", {62'd0, ram_cs, ram_we}, {62'd0, 1'b1, we});
    chk("access_addr", {59'd0, ram_addr}, {59'd0, addr});
    chk("access_wdata", {32'd0, ram_wdata}, {32'd0, wdata});
    chk("access_ack", {62'd0, ack1, ack0}, 64'd0);
    @(negedge clock);
    chk("resp_ack", {62'd0, ack1, ack0}, id ? 64'd2 : 64'd1);
    chk("resp_gnt_cs_we", {60'd0, gnt1, gnt0, ram_cs, ram_we}, 64'd0);
    chk("resp_rdata", {32'd0, rdata}, {32'd0, exp_rdata});
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  typedef struct {
    logic        id;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // id, we, addr, wdata, rdata expected at ack (writes leave rdata alone)
    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h1000_0007};
    vecs[1] = '{1'b0, 1'b0, 5'd5,  32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 5'd10, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 5'd10, 32'h0000_0000, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 5'd31, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 1'b1, 5'd0,  32'hA5A5_A5A5, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 32'hA5A5_A5A5};
    vecs[8] = '{1'b1, 1'b0, 5'd20, 32'h0000_0000, 32'h1000_0014};
    vecs[9] = '{1'b0, 1'b0, 5'd5,  32'h0000_0000, 32'hDEAD_BEEF};

    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 5'd0; wdata1 = 32'h0;

    // Reset held with a pending request: everything stays at zero.
    repeat (3) @(negedge clock);
    chk("reset_ctrl", {58'd0, gnt0, gnt1, ack0, ack1, ram_cs, ram_we}, 64'd0);
    chk("reset_addr_wdata", {27'd0, ram_addr, ram_wdata}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_gnt0", {60'd0, gnt1, gnt0, ram_cs, ram_we}, 64'h6);
    chk("post_reset_addr", {59'd0, ram_addr}, 64'd7);
    @(negedge clock);
    chk("post_reset_ack0", {62'd0, ack1, ack0}, 64'd1);
    chk("post_reset_rdata", {32'd0, rdata}, 64'h1000_0007);
    req0 = 1'b0;

    // Table of single-requester transactions.
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // No requests: bus idle, rdata holds the last read.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ctrl", {58'd0, gnt0, gnt1, ack0, ack1, ram_cs, ram_we}, 64'd0);
      chk("idle_rdata", {32'd0, rdata}, 64'hDEAD_BEEF);
    end

    // Command inputs change during ACCESS; the latched command must win.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd12; wdata0 = 32'h0BAD_F00D;
    @(negedge clock);
    addr0 = 5'd13; wdata0 = 32'h0; we0 = 1'b0;
    #2;
    chk("stable_addr", {59'd0, ram_addr}, 64'd12);
    chk("stable_wdata", {32'd0, ram_wdata}, 64'h0BAD_F00D);
    chk("stable_we", {63'd0, ram_we}, 64'd1);
    @(negedge clock);
    chk("stable_ack", {62'd0, ack1, ack0}, 64'd1);
    req0 = 1'b0;
    do_txn(1'b0, 1'b0, 5'd12, 32'h0, 32'h0BAD_F00D);
    do_txn(1'b0, 1'b0, 5'd13, 32'h0, 32'h1000_000D);

    // Reset in the middle of ACCESS aborts the write.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'h1;
    @(posedge clock);
    #2;
    chk("midacc_cs_before", {62'd0, ram_cs, ram_we}, 64'd3);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("midacc_cs_dropped", {60'd0, gnt0, gnt1, ram_cs, ram_we}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_txn(1'b0, 1'b0, 5'd3, 32'h0, 32'h1000_0003);

    // Both requesters held continuously, from a fresh reset.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2; wdata1 = 32'h0;
    for (int n = 1; n <= 12; n++) begin
      int   k;
      int   ph;
      logic w;
      @(negedge clock);
      k  = (n - 1) / 3;
      ph = (n - 1) % 3;
`ifdef RAM_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = k[0];
`endif
      if (ph == 0) begin
        chk("both_gnt", {60'd0, gnt1, gnt0, ack1, ack0}, w ? 64'h8 : 64'h4);
        chk("both_cs", {63'd0, ram_cs}, 64'd1);
      end else if (ph == 1) begin
        chk("both_ack", {60'd0, gnt1, gnt0, ack1, ack0}, w ? 64'h2 : 64'h1);
        chk("both_rdata", {32'd0, rdata}, w ? 64'h1000_0002 : 64'h1000_0001);
      end else begin
        chk("both_idle", {59'd0, gnt1, gnt0, ack1, ack0, ram_cs}, 64'd0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
